// File: rtl/switch_cfg_pkg.sv
// switch_cfg_pkg: switch codes and controller state shared by the switch config controller.
package switch_cfg_pkg;

    typedef logic [1:0] sw_code_t;

    localparam sw_code_t SW_OFF = 2'b00;
    localparam sw_code_t SW_FWD = 2'b11;
    localparam sw_code_t SW_REV = 2'b10;

    typedef enum logic {IDLE, DEAD} state_t;

endpackage

// File: rtl/switch_config_ctrl_dead_time_counter.sv
// dead_time_counter: loadable down-counter that holds at zero and flags when it has run out.
module dead_time_counter #(
    parameter int DEAD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = load ? CNT_W'(DEAD_CYCLES - 1) : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    assign zero = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/switch_config_ctrl.sv
// switch_config_ctrl: shadow-banked switch codes committed break-before-make so no two drivers
// ever fight on a net while the switch topology changes.
module switch_config_ctrl
    import switch_cfg_pkg::*;
#(
    parameter int N_SW        = 8,
    parameter int DEAD_CYCLES = 4,
    parameter int IDX_W       = (N_SW > 1) ? $clog2(N_SW) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [1:0]        cfg_code,
    input  logic              commit,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2*N_SW-1:0] enable_dir
);

    localparam logic [IDX_W:0] N_SW_L = (IDX_W + 1)'(N_SW);

    state_t            state_q, state_d;
    logic [2*N_SW-1:0] shadow_q, shadow_d, enable_dir_q, enable_dir_d;
    logic [2*N_SW-1:0] shadow_eff, masked;
    logic [N_SW-1:0]   chg;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              idle, idx_ok, wr_ok, load, cnt_zero;

    assign idle       = (state_q == IDLE);
    assign idx_ok     = ({1'b0, cfg_idx} < N_SW_L);
    assign wr_ok      = cfg_valid && idle && idx_ok;
    assign cfg_ready  = idle;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign enable_dir = enable_dir_q;

    // A write accepted in the commit cycle joins that commit.
    always_comb begin
        shadow_eff = shadow_q;
        masked     = enable_dir_q;
        chg        = '0;
        for (int i = 0; i < N_SW; i++) begin
            if (wr_ok && cfg_idx == IDX_W'(i)) shadow_eff[2*i +: 2] = cfg_code;
            chg[i] = (shadow_eff[2*i +: 2] != enable_dir_q[2*i +: 2]);
            if (chg[i]) masked[2*i +: 2] = SW_OFF;
        end
    end

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        enable_dir_d = enable_dir_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        load         = 1'b0;
        if (idle) begin
            shadow_d = shadow_eff;
            err_d    = cfg_valid && !idx_ok;
            if (commit && chg == '0) begin
                done_d = 1'b1;
            end else if (commit) begin
                enable_dir_d = masked;
                state_d      = DEAD;
                busy_d       = 1'b1;
                load         = 1'b1;
            end
        end else begin
            err_d = commit;
            if (cnt_zero) begin
                enable_dir_d = shadow_q;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
        end
    end

    dead_time_counter #(.DEAD_CYCLES(DEAD_CYCLES)) u_dead_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .en   (state_q == DEAD),
        .zero (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            enable_dir_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            enable_dir_q <= enable_dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_switch_config_ctrl.sv
// tb_switch_config_ctrl: directed vectors with a done/err scoreboard for an 8-switch and a 6-switch controller.
module tb_switch_config_ctrl;
    import switch_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v8 = 1'b0, c8 = 1'b0;
    logic [2:0]  i8 = '0;
    logic [1:0]  code8 = '0;
    logic        ready8, busy8, done8, err8;
    logic [15:0] ed8;

    logic        v6 = 1'b0, c6 = 1'b0;
    logic [2:0]  i6 = '0;
    logic [1:0]  code6 = '0;
    logic        ready6, busy6, done6, err6;
    logic [11:0] ed6;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_done8[$];
    logic [11:0] exp_done6[$];
    int          exp_err8 = 0;
    int          exp_err6 = 0;

    switch_config_ctrl #(.N_SW(8), .DEAD_CYCLES(4)) u8 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(v8), .cfg_ready(ready8), .cfg_idx(i8),
        .cfg_code(code8), .commit(c8), .busy(busy8), .done(done8), .err(err8), .enable_dir(ed8)
    );

    switch_config_ctrl #(.N_SW(6), .DEAD_CYCLES(4)) u6 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(v6), .cfg_ready(ready6), .cfg_idx(i6),
        .cfg_code(code6), .commit(c6), .busy(busy6), .done(done6), .err(err6), .enable_dir(ed6)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr8(input logic [2:0] idx, input sw_code_t code);
        v8 = 1'b1; i8 = idx; code8 = code;
        cyc();
        v8 = 1'b0;
    endtask

    task automatic wr6(input logic [2:0] idx, input sw_code_t code);
        v6 = 1'b1; i6 = idx; code6 = code;
        cyc();
        v6 = 1'b0;
    endtask

    task automatic cm8();
        c8 = 1'b1;
        cyc();
        c8 = 1'b0;
    endtask

    task automatic cm6();
        c6 = 1'b1;
        cyc();
        c6 = 1'b0;
    endtask

    // Commit on u8 and follow the 4-cycle off window to the new codes.
    task automatic run8(input string name, input logic [15:0] off_val, input logic [15:0] new_val);
        exp_done8.push_back(new_val);
        cm8();
        for (int k = 1; k <= 4; k++) begin
            chk({name, "_off"}, 32'(ed8), 32'(off_val));
            chk({name, "_busy"}, 32'(busy8), 1);
            chk({name, "_ready"}, 32'(ready8), 0);
            cyc();
        end
        chk({name, "_new"}, 32'(ed8), 32'(new_val));
        chk({name, "_done"}, 32'(done8), 1);
        chk({name, "_idle"}, 32'(busy8), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done8) begin
                if (exp_done8.size() == 0) chk("sb_done8_unexpected", 32'(done8), 0);
                else chk("sb_done8", 32'(ed8), 32'(exp_done8.pop_front()));
            end
            if (err8) begin
                if (exp_err8 == 0) chk("sb_err8_unexpected", 32'(err8), 0);
                else exp_err8--;
            end
            if (done6) begin
                if (exp_done6.size() == 0) chk("sb_done6_unexpected", 32'(done6), 0);
                else chk("sb_done6", 32'(ed6), 32'(exp_done6.pop_front()));
            end
            if (err6) begin
                if (exp_err6 == 0) chk("sb_err6_unexpected", 32'(err6), 0);
                else exp_err6--;
            end
        end
    end

    initial begin
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("rst_ed8", 32'(ed8), 0);
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_ready8", 32'(ready8), 1);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_err8", 32'(err8), 0);
        chk("rst_ed6", 32'(ed6), 0);

        wr8(3'd3, SW_FWD);
        run8("t2", 16'h0000, 16'h00C0);

        wr8(3'd0, SW_FWD);
        wr8(3'd1, SW_REV);
        run8("t3a", 16'h00C0, 16'h00CB);
        wr8(3'd0, SW_REV);
        run8("t3b", 16'h00C8, 16'h00CA);

        exp_done8.push_back(16'h00CA);
        cm8();
        chk("t4_done", 32'(done8), 1);
        chk("t4_busy", 32'(busy8), 0);
        chk("t4_ed", 32'(ed8), 32'h00CA);
        cyc();
        chk("t4_busy2", 32'(busy8), 0);
        chk("t4_done2", 32'(done8), 0);

        exp_done8.push_back(16'h0CCA);
        v8 = 1'b1; i8 = 3'd5; code8 = SW_FWD; c8 = 1'b1;
        cyc();
        v8 = 1'b0; c8 = 1'b0;
        chk("t5_busy1", 32'(busy8), 1);
        chk("t5_off1", 32'(ed8), 32'h00CA);
        cyc();
        exp_err8++;
        c8 = 1'b1;
        chk("t5_busy2", 32'(busy8), 1);
        cyc();
        c8 = 1'b0;
        chk("t5_err", 32'(err8), 1);
        chk("t5_busy3", 32'(busy8), 1);
        chk("t5_off3", 32'(ed8), 32'h00CA);
        cyc();
        chk("t5_busy4", 32'(busy8), 1);
        chk("t5_err_pulse", 32'(err8), 0);
        cyc();
        chk("t5_new", 32'(ed8), 32'h0CCA);
        chk("t5_done", 32'(done8), 1);
        chk("t5_idle", 32'(busy8), 0);

        exp_err6++;
        wr6(3'd7, SW_FWD);
        chk("t6_err", 32'(err6), 1);
        chk("t6_ed", 32'(ed6), 0);
        cyc();
        exp_done6.push_back(12'h000);
        cm6();
        chk("t6_nochg_done", 32'(done6), 1);
        chk("t6_nochg_busy", 32'(busy6), 0);
        chk("t6_nochg_ed", 32'(ed6), 0);
        wr6(3'd2, SW_FWD);
        exp_done6.push_back(12'h030);
        cm6();
        v6 = 1'b1; i6 = 3'd4; code6 = SW_REV;
        for (int k = 1; k <= 4; k++) begin
            chk("t6_ready_busy", 32'(ready6), 0);
            chk("t6_off", 32'(ed6), 0);
            cyc();
        end
        chk("t6_done", 32'(done6), 1);
        chk("t6_ed_new", 32'(ed6), 32'h030);
        chk("t6_ready_idle", 32'(ready6), 1);
        cyc();
        v6 = 1'b0;
        exp_done6.push_back(12'h230);
        cm6();
        for (int k = 1; k <= 4; k++) begin
            chk("t6_held_off", 32'(ed6), 32'h030);
            chk("t6_held_busy", 32'(busy6), 1);
            cyc();
        end
        chk("t6_held_new", 32'(ed6), 32'h230);
        chk("t6_held_done", 32'(done6), 1);

        wr8(3'd6, SW_FWD);
        cm8();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_ed", 32'(ed8), 0);
        chk("t1_busy", 32'(busy8), 0);
        chk("t1_ready", 32'(ready8), 1);
        chk("t1_done", 32'(done8), 0);
        chk("t1_err", 32'(err8), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        exp_done8.push_back(16'h0000);
        cm8();
        chk("t1_shadow_lost_done", 32'(done8), 1);
        chk("t1_shadow_lost_ed", 32'(ed8), 0);
        chk("t1_shadow_lost_busy", 32'(busy8), 0);

        repeat (2) cyc();
        chk("sb_done8_drained", 32'(exp_done8.size()), 0);
        chk("sb_done6_drained", 32'(exp_done6.size()), 0);
        chk("sb_err8_drained", 32'(exp_err8), 0);
        chk("sb_err6_drained", 32'(exp_err6), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
